// File: rtl/enc_pkg.sv
// Shared definitions for the eight-line debounced priority encoder:
// sizes, FSM state type and the encoding helpers.
package enc_pkg;

    localparam int NUM_LINES = 8;
    localparam int CODE_W    = 3;

    localparam logic [NUM_LINES-1:0] ALL_RELEASED = 8'hFF;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESENT      = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    // Index of the lowest asserted (low) line; the lowest index wins.
    function automatic logic [CODE_W-1:0] prio_code(input logic [NUM_LINES-1:0] v_n);
        logic [CODE_W-1:0] c;
        c = {CODE_W{1'b0}};
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (!v_n[i]) begin
                c = CODE_W'(i);
            end
        end
        return c;
    endfunction

    // Clearing the lowest set bit of the active-high view leaves something
    // only when at least two lines are asserted.
    function automatic logic multi_low(input logic [NUM_LINES-1:0] v_n);
        logic [NUM_LINES-1:0] low;
        low = ~v_n;
        return |(low & (low - {{(NUM_LINES-1){1'b0}}, 1'b1}));
    endfunction

endpackage

// File: rtl/debounce_vec.sv
// Two-flop synchronizer followed by a whole-vector debouncer: the stable
// output only takes a value the synchronized input has held long enough.
module debounce_vec #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async_n,
    output logic [WIDTH-1:0] o_stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);
    // The sample that loads the candidate counts as the first of the window.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_changed;

    // Run-length counter: restarts on any change, saturates once settled.
    always_comb begin
        w_changed  = (r_sync2 != r_cand);
        w_cnt_next = r_cnt;
        if (w_changed) begin
            w_cnt_next = {CNT_W{1'b0}};
        end else if (r_cnt != CNT_SAT) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // Synchronizer, candidate, counter and stable registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= {WIDTH{1'b1}};
            r_sync2  <= {WIDTH{1'b1}};
            r_cand   <= {WIDTH{1'b1}};
            r_stable <= {WIDTH{1'b1}};
            r_cnt    <= {CNT_W{1'b0}};
        end else begin
            r_sync1 <= i_async_n;
            r_sync2 <= r_sync1;
            r_cand  <= r_sync2;
            r_cnt   <= w_cnt_next;
            if (w_cnt_next == CNT_LOAD) begin
                r_stable <= r_sync2;
            end else begin
                r_stable <= r_stable;
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/encoder_debounce_a3.sv
// Debounced eight-line priority encoder: one event per press, presented
// with a valid/ready handshake and held until the consumer accepts it.
module encoder_debounce_a3
    import enc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LINES-1:0] lines_n,
    input  logic                 ready,
    output logic [CODE_W-1:0]    code,
    output logic                 valid,
    output logic                 multi
);

    logic [NUM_LINES-1:0] w_stable;

    state_t            r_state;
    state_t            w_state_next;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_next;
    logic              r_multi;
    logic              w_multi_next;
    logic              r_valid;
    logic              w_valid_next;

    debounce_vec #(
        .WIDTH           (NUM_LINES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .i_async_n (lines_n),
        .o_stable  (w_stable)
    );

    // Next state and next registered outputs of the event FSM.
    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
        w_multi_next = r_multi;
        w_valid_next = r_valid;
        case (r_state)
            IDLE: begin
                if (w_stable != ALL_RELEASED) begin
                    w_state_next = PRESENT;
                    w_code_next  = prio_code(w_stable);
                    w_multi_next = multi_low(w_stable);
                    w_valid_next = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            PRESENT: begin
                // The captured event is frozen here; only acceptance moves on.
                if (r_valid && ready) begin
                    w_state_next = (w_stable == ALL_RELEASED) ? IDLE : WAIT_RELEASE;
                    w_code_next  = {CODE_W{1'b0}};
                    w_multi_next = 1'b0;
                    w_valid_next = 1'b0;
                end else begin
                    w_state_next = PRESENT;
                end
            end
            WAIT_RELEASE: begin
                if (w_stable == ALL_RELEASED) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = WAIT_RELEASE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_code_next  = {CODE_W{1'b0}};
                w_multi_next = 1'b0;
                w_valid_next = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_code  <= {CODE_W{1'b0}};
            r_multi <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_code  <= w_code_next;
            r_multi <= w_multi_next;
            r_valid <= w_valid_next;
        end
    end

    assign code  = r_code;
    assign multi = r_multi;
    assign valid = r_valid;

endmodule

// File: tb/tb_encoder_debounce_a3.sv
// Bench for encoder_debounce_a3: directed scenarios on a 4-cycle instance,
// plus a random bounce sweep on 4-cycle and 1-cycle instances vs a model.
module tb_encoder_debounce_a3;

    logic       clk;
    logic       reset;
    logic [7:0] lines_n;
    logic       ready;
    logic [2:0] c4, c1;
    logic       v4, v1, m4, m1;

    int n_tests = 0;
    int n_fail  = 0;

    encoder_debounce_a3 #(.DEBOUNCE_CYCLES(4)) u4 (
        .clk(clk), .reset(reset), .lines_n(lines_n), .ready(ready),
        .code(c4), .valid(v4), .multi(m4)
    );

    encoder_debounce_a3 #(.DEBOUNCE_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .lines_n(lines_n), .ready(ready),
        .code(c1), .valid(v1), .multi(m1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, index 0 = 4-cycle instance, 1 = 1-cycle instance.
    logic [7:0] samp[$];
    logic [7:0] m_stable[2];
    logic       m_pend[2];
    logic       m_wait[2];
    logic [2:0] m_code[2];
    logic       m_multi[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        lines_n = 8'hFF;
        ready   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 50; k++) begin
            tick();
            n_tests++;
            if ({v4, c4, m4} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_d4 cyc=%0d: got v=%0b code=%0d multi=%0b, expected all 0", k, v4, c4, m4);
            end
            n_tests++;
            if ({v1, c1, m1} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_d1 cyc=%0d: got v=%0b code=%0d multi=%0b, expected all 0", k, v1, c1, m1);
            end
        end
    endtask

    task automatic test_single_press();
        logic [4:0] exp;
        for (int pass = 0; pass < 2; pass++) begin
            ready   = 1'b1;
            lines_n = 8'hFB;
            for (int k = 1; k <= 20; k++) begin
                tick();
                exp = (k == 7) ? 5'b1_010_0 : 5'b0;
                n_tests++;
                if ({v4, c4, m4} !== exp) begin
                    n_fail++;
                    $display("FAIL single_press pass=%0d k=%0d: got v=%0b code=%0d multi=%0b, expected v=%0b code=%0d multi=%0b",
                             pass, k, v4, c4, m4, exp[4], exp[3:1], exp[0]);
                end
            end
            lines_n = 8'hFF;
            for (int k = 0; k < 12; k++) begin
                tick();
                n_tests++;
                if (v4 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_release pass=%0d k=%0d: got v=%0b, expected 0", pass, k, v4);
                end
            end
        end
    endtask

    task automatic test_multi_hold();
        logic [4:0] exp;
        ready   = 1'b0;
        lines_n = 8'h7E;
        for (int k = 1; k <= 21; k++) begin
            tick();
            exp = (k >= 7 && k <= 20) ? 5'b1_000_1 : 5'b0;
            n_tests++;
            if ({v4, c4, m4} !== exp) begin
                n_fail++;
                $display("FAIL multi_hold k=%0d: got v=%0b code=%0d multi=%0b, expected v=%0b code=%0d multi=%0b",
                         k, v4, c4, m4, exp[4], exp[3:1], exp[0]);
            end
            if (k == 10) lines_n = 8'hFF;
            if (k == 20) ready = 1'b1;
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++;
            if (v4 !== 1'b0) begin
                n_fail++;
                $display("FAIL multi_after_accept k=%0d: got v=%0b, expected 0", k, v4);
            end
        end
    endtask

    task automatic test_glitch();
        logic [4:0] exp;
        ready   = 1'b1;
        lines_n = 8'hDF;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 3) lines_n = 8'hFF;
            n_tests++;
            if (v4 !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_short k=%0d: got v=%0b, expected 0", k, v4);
            end
        end
        lines_n = 8'hDF;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 4) lines_n = 8'hFF;
            exp = (k == 7) ? 5'b1_101_0 : 5'b0;
            n_tests++;
            if ({v4, c4, m4} !== exp) begin
                n_fail++;
                $display("FAIL glitch_long k=%0d: got v=%0b code=%0d multi=%0b, expected v=%0b code=%0d multi=%0b",
                         k, v4, c4, m4, exp[4], exp[3:1], exp[0]);
            end
        end
    endtask

    task automatic test_reset_during_present();
        logic [4:0] exp;
        ready   = 1'b0;
        lines_n = 8'h7F;
        for (int k = 1; k <= 7; k++) tick();
        n_tests++;
        if ({v4, c4, m4} !== 5'b1_111_0) begin
            n_fail++;
            $display("FAIL rst_present_pre: got v=%0b code=%0d multi=%0b, expected v=1 code=7 multi=0", v4, c4, m4);
        end
        reset = 1'b1;
        ready = 1'b1;
        tick();
        n_tests++;
        if ({v4, c4, m4} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_present_drop: got v=%0b code=%0d multi=%0b, expected all 0", v4, c4, m4);
        end
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = (k == 7) ? 5'b1_111_0 : 5'b0;
            n_tests++;
            if ({v4, c4, m4} !== exp) begin
                n_fail++;
                $display("FAIL rst_present_again k=%0d: got v=%0b code=%0d multi=%0b, expected v=%0b code=%0d multi=%0b",
                         k, v4, c4, m4, exp[4], exp[3:1], exp[0]);
            end
        end
        lines_n = 8'hFF;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_d1_latency();
        logic [4:0] exp;
        do_reset();
        ready   = 1'b1;
        lines_n = 8'hF7;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp = (k == 4) ? 5'b1_011_0 : 5'b0;
            n_tests++;
            if ({v1, c1, m1} !== exp) begin
                n_fail++;
                $display("FAIL d1_latency k=%0d: got v=%0b code=%0d multi=%0b, expected v=%0b code=%0d multi=%0b",
                         k, v1, c1, m1, exp[4], exp[3:1], exp[0]);
            end
        end
        lines_n = 8'hFF;
        for (int k = 0; k < 8; k++) tick();
    endtask

    // One clock of the behavioural model: the handshake decision uses the
    // debounced value from before the edge, then debounced value is refreshed
    // from the last d synchronized samples (each sample is two edges old).
    task automatic model_step(input int idx, input int d, input logic rdy);
        int         sz;
        int         zeros;
        int         first;
        logic       all_eq;
        logic [7:0] s;
        if (m_pend[idx]) begin
            if (rdy) begin
                m_pend[idx] = 1'b0;
                m_wait[idx] = (m_stable[idx] != 8'hFF);
            end
        end else if (m_wait[idx]) begin
            if (m_stable[idx] == 8'hFF) m_wait[idx] = 1'b0;
        end else if (m_stable[idx] != 8'hFF) begin
            zeros = 0;
            first = -1;
            for (int i = 0; i < 8; i++) begin
                if (m_stable[idx][i] == 1'b0) begin
                    zeros++;
                    if (first < 0) first = i;
                end
            end
            m_pend[idx]  = 1'b1;
            m_code[idx]  = 3'(first);
            m_multi[idx] = (zeros >= 2);
        end
        sz = samp.size();
        s  = samp[sz-3];
        all_eq = 1'b1;
        for (int j = 0; j < d; j++) begin
            if (samp[sz-3-j] != s) all_eq = 1'b0;
        end
        if (all_eq) m_stable[idx] = s;
    endtask

    task automatic test_random_bounce();
        int         hold;
        int         kind;
        logic [7:0] onehot;
        logic [7:0] cur_lines;
        logic       cur_ready;
        logic [4:0] exp;
        do_reset();
        samp.delete();
        for (int i = 0; i < 8; i++) samp.push_back(8'hFF);
        for (int i = 0; i < 2; i++) begin
            m_stable[i] = 8'hFF;
            m_pend[i]   = 1'b0;
            m_wait[i]   = 1'b0;
            m_code[i]   = 3'd0;
            m_multi[i]  = 1'b0;
        end
        hold = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (hold == 0) begin
                kind = $urandom_range(0, 3);
                if (kind == 0 || kind == 1) begin
                    lines_n = 8'hFF;
                end else if (kind == 2) begin
                    onehot  = 8'd1 << $urandom_range(0, 7);
                    lines_n = ~onehot;
                end else begin
                    lines_n = 8'($urandom_range(0, 255));
                end
                hold = $urandom_range(1, 7);
            end
            hold--;
            ready     = ($urandom_range(0, 3) != 0);
            cur_lines = lines_n;
            cur_ready = ready;
            tick();
            samp.push_back(cur_lines);
            model_step(0, 4, cur_ready);
            model_step(1, 1, cur_ready);
            exp = m_pend[0] ? {1'b1, m_code[0], m_multi[0]} : 5'b0;
            n_tests++;
            if ({v4, c4, m4} !== exp) begin
                n_fail++;
                $display("FAIL random_d4 cyc=%0d: got v=%0b code=%0d multi=%0b, expected v=%0b code=%0d multi=%0b",
                         cyc, v4, c4, m4, exp[4], exp[3:1], exp[0]);
            end
            exp = m_pend[1] ? {1'b1, m_code[1], m_multi[1]} : 5'b0;
            n_tests++;
            if ({v1, c1, m1} !== exp) begin
                n_fail++;
                $display("FAIL random_d1 cyc=%0d: got v=%0b code=%0d multi=%0b, expected v=%0b code=%0d multi=%0b",
                         cyc, v1, c1, m1, exp[4], exp[3:1], exp[0]);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        lines_n = 8'hFF;
        ready   = 1'b0;
        test_reset();
        test_single_press();
        test_multi_hold();
        test_glitch();
        test_reset_during_present();
        test_d1_latency();
        test_random_bounce();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_debounce_a3.md
ENCODER_DEBOUNCE_A3 -- requirements
Module: encoder_debounce_a3

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, cycles the synchronized input vector must remain unchanged before acceptance; legal range 1..2^20.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 lines_n  input  8  asynchronous active-low request lines; bit i low = line i asserted.
REQ-005 code  output  3  binary index of the captured line.
REQ-006 valid  output  1  code/multi hold a captured event.
REQ-007 ready  input  1  consumer accepts the event when high with valid.
REQ-008 multi  output  1  more than one line was low at capture.

Function
REQ-009 lines_n SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Debounce: counter clears whenever synchronized vector differs from the candidate register, and candidate loads the new vector; after DEBOUNCE_CYCLES consecutive equal cycles, stable register loads candidate.
REQ-011 Encoding SHALL be priority, lowest low bit wins: stable 8'b1111_1110 -> code 3'b000, 8'b0111_1111 -> 3'b111, 8'b1111_0011 -> 3'b010.
REQ-012 multi SHALL be 1 iff two or more stable bits are low at capture.
REQ-013 FSM states: IDLE, PRESENT, WAIT_RELEASE.
REQ-014 IDLE -> PRESENT when stable changes from 8'hFF to any value with a low bit; code and multi captured in the same edge; valid=1 in PRESENT.
REQ-015 PRESENT: code, multi, valid SHALL hold constant until valid&&ready; stable changes during PRESENT are ignored for reporting.
REQ-016 On valid&&ready: if stable==8'hFF go IDLE, else go WAIT_RELEASE; valid=0 next cycle.
REQ-017 WAIT_RELEASE -> IDLE when stable==8'hFF; no new event while any line remains low.
REQ-018 Release before ready SHALL NOT drop the event; it stays presented until accepted.
REQ-019 ready high when valid rises SHALL complete the handshake in that first cycle (valid high exactly one cycle).
REQ-020 Latency: lines_n held constant from edge N yields valid=1 at edge N+DEBOUNCE_CYCLES+3, exactly.
REQ-021 Glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no event and leave stable unchanged.
REQ-022 Debounce counter SHALL saturate, never wrap, while input stays constant.
REQ-023 code, multi SHALL be 0 in IDLE and WAIT_RELEASE.

Reset
REQ-024 reset SHALL set synchronizer flops, candidate and stable to 8'hFF, counter to 0, state to IDLE, valid/code/multi to 0, effective at the next rising edge.
REQ-025 Reset during PRESENT SHALL discard the pending event; a line still held low after reset SHALL be reported anew per REQ-020 timing from the reset-release edge.
REQ-026 ready SHALL be ignored while reset is high.

Structure
REQ-027 Shared package enc_pkg SHALL hold NUM_LINES=8, CODE_W=3, and the state enum type (IDLE, PRESENT, WAIT_RELEASE).
REQ-028 Synchronizer plus debounce counter SHALL be one sub-module, debounce_vec, parameterized by width and DEBOUNCE_CYCLES; encoder and FSM live in the top.
REQ-029 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-030 reset 2 cycles, lines_n=8'hFF -> valid=0, code=0, multi=0 for 50 cycles.
REQ-031 lines_n=8'hFB held, ready=1 -> valid=1 for exactly one cycle at edge 7 after change, code=3'b010, multi=0; no further event until release then re-press.
REQ-032 lines_n=8'h7E, ready=0 for 20 cycles -> code=3'b000, multi=1 held constant; lines released at cycle 10 -> event still presented; ready=1 -> valid drops, state IDLE.
REQ-033 3-cycle low pulse on bit 5 -> no valid; 4-cycle stable pulse -> one event code=3'b101.
REQ-034 reset asserted while valid=1 and bit 7 still low -> valid=0 next edge; after release event re-reported with code=3'b111 at edge 7.
REQ-035 DEBOUNCE_CYCLES=1: bit 3 low held -> valid at edge 4, code=3'b011; random bounce sweep checks no spurious or lost events against a reference model.
